// File: rtl/crc_pkg.sv
// Shared definitions for the bit-serial CRC generator and checker:
// FSM state encoding and the commonly used generator polynomials.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    localparam logic [8:0]  CRC8_POLY        = 9'h107;
    localparam logic [16:0] CRC16_CCITT_POLY = 17'h11021;

endpackage

// File: rtl/crc_check_if.sv
// Request/result bundle of the CRC checker. The master side issues a check
// (start, codeword, poly); the slave side reports busy/done and the results.
interface crc_check_if #(
    parameter int width      = 32,
    parameter int poly_width = 9
);
    logic                          start;
    logic [width+poly_width-2:0]   codeword;
    logic [poly_width-1:0]         poly;
    logic                          busy;
    logic                          done;
    logic                          crc_ok;
    logic [poly_width-2:0]         syndrome;

    modport master (
        output start, codeword, poly,
        input  busy, done, crc_ok, syndrome
    );

    modport slave (
        input  start, codeword, poly,
        output busy, done, crc_ok, syndrome
    );
endinterface

// File: rtl/crc_div_step.sv
// One GF(2) long-division step: if the MSB of the work word is set, subtract
// (XOR) the aligned divisor, then shift left by one. The bit shifted out is
// discarded. Shared by generator and checker so both ends divide identically.
module crc_div_step #(
    parameter int n = 40
) (
    input  logic [n-1:0] w,
    input  logic [n-1:0] d,
    output logic [n-1:0] w_next
);
    logic [n-1:0] wx;

    // Conditional XOR, bit by bit, gated by the current leading bit.
    for (genvar gi = 0; gi < n; gi++) begin : g_xor
        assign wx[gi] = w[gi] ^ (w[n-1] & d[gi]);
    end

    assign w_next = wx << 1;
endmodule

// File: rtl/crc_check.sv
// Receive-side CRC checker. Divides the received codeword (message followed
// by its CRC) by the generator polynomial one message bit per clock and
// reports the remainder (syndrome) plus a pass flag when finished.
module crc_check
    import crc_pkg::*;
#(
    parameter int width      = 32,
    parameter int poly_width = 9
) (
    input  logic        clk,
    input  logic        reset,
    crc_check_if.slave  bus
);
    localparam int CW = width + poly_width - 1;   // codeword length
    localparam int SW = poly_width - 1;           // CRC / syndrome length

    crc_state_t      state_reg, state_next;
    logic [CW-1:0]   w_reg, w_next;
    logic [CW-1:0]   d_reg, d_next;
    logic [7:0]      counter_reg, counter_next;
    logic [SW-1:0]   syndrome_reg, syndrome_next;
    logic            crc_ok_reg, crc_ok_next;
    logic            done_reg, done_next;
    logic [CW-1:0]   w_step;

    crc_div_step #(.n(CW)) u_step (
        .w      (w_reg),
        .d      (d_reg),
        .w_next (w_step)
    );

    // State and datapath registers; reset aborts any check in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            w_reg        <= '0;
            d_reg        <= '0;
            counter_reg  <= '0;
            syndrome_reg <= '0;
            crc_ok_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            w_reg        <= w_next;
            d_reg        <= d_next;
            counter_reg  <= counter_next;
            syndrome_reg <= syndrome_next;
            crc_ok_reg   <= crc_ok_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and datapath control. Inputs are captured only on the
    // accepted start, so later changes cannot disturb a running check.
    always_comb begin
        state_next    = state_reg;
        w_next        = w_reg;
        d_next        = d_reg;
        counter_next  = counter_reg;
        syndrome_next = syndrome_reg;
        crc_ok_next   = crc_ok_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    w_next       = bus.codeword;
                    // Align the polynomial MSB with the codeword MSB.
                    d_next       = CW'(bus.poly) << (width - 1);
                    counter_next = 8'(width);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                w_next       = w_step;
                counter_next = counter_reg - 8'd1;
                if (counter_reg == 8'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // After width steps the remainder sits in the top SW bits.
                syndrome_next = w_reg[CW-1 -: SW];
                crc_ok_next   = (w_reg[CW-1 -: SW] == '0);
                done_next     = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.crc_ok   = crc_ok_reg;
    assign bus.syndrome = syndrome_reg;
endmodule

// File: tb/tb_crc_check.sv
// Testbench for crc_check: directed vectors, latency/busy timing, ignored
// restarts, reset abort and randomized frames checked against a textbook
// polynomial long-division model.
module tb_crc_check;
    import crc_pkg::*;

    localparam int WIDTH = 32;
    localparam int PW    = 9;
    localparam int CW    = WIDTH + PW - 1;
    localparam int SW    = PW - 1;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    crc_check_if #(.width(WIDTH), .poly_width(PW)) bus ();

    crc_check #(.width(WIDTH), .poly_width(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of cw(x) divided by p(x), by plain long division over GF(2).
    function automatic logic [SW-1:0] ref_rem(input logic [CW-1:0] cw, input logic [PW-1:0] p);
        logic [CW-1:0] r;
        logic [CW-1:0] pe;
        r  = cw;
        pe = CW'(p);
        for (int i = CW - 1; i >= SW; i--) begin
            if (r[i]) r = r ^ (pe << (i - SW));
        end
        return r[SW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one check and wait for done. lat = edges from the start edge to
    // the edge after which done is visible; busy_cnt = cycles seen with busy.
    task automatic run_check(input logic [CW-1:0] cw, input logic [PW-1:0] p,
                             output int lat, output int busy_cnt);
        bus.codeword = cw;
        bus.poly     = p;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.codeword = '0;
        bus.poly  = CRC8_POLY;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.crc_ok !== 1'b0) begin fails++; $display("FAIL reset_crc_ok got=%b exp=0", bus.crc_ok); end
        checks++; if (bus.syndrome !== '0) begin fails++; $display("FAIL reset_syndrome got=%h exp=00", bus.syndrome); end
        reset = 1'b0;
        tick();
        $display("reset: busy=%b done=%b crc_ok=%b syndrome=%h", bus.busy, bus.done, bus.crc_ok, bus.syndrome);
    endtask

    task automatic test_zero_timing();
        int lat, bc;
        run_check(40'h00_0000_0000, CRC8_POLY, lat, bc);
        checks++; if (lat !== WIDTH + 1) begin fails++; $display("FAIL zero_latency got=%0d exp=%0d", lat, WIDTH + 1); end
        checks++; if (bc !== WIDTH + 1) begin fails++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bc, WIDTH + 1); end
        checks++; if (bus.syndrome !== 8'h00) begin fails++; $display("FAIL zero_syndrome got=%h exp=00", bus.syndrome); end
        checks++; if (bus.crc_ok !== 1'b1) begin fails++; $display("FAIL zero_crc_ok got=%b exp=1", bus.crc_ok); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL zero_busy_at_done got=%b exp=0", bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse got=%b exp=0", bus.done); end
        $display("zero: latency=%0d busy_cycles=%0d syndrome=%h crc_ok=%b", lat, bc, bus.syndrome, bus.crc_ok);
    endtask

    task automatic test_vectors();
        logic [CW-1:0] cws [3];
        logic [SW-1:0] exp_syn [3];
        int lat, bc;
        cws[0] = 40'h00_0000_0107; exp_syn[0] = 8'h00;
        cws[1] = 40'h00_0000_0106; exp_syn[1] = 8'h01;
        cws[2] = 40'h00_0000_0007; exp_syn[2] = 8'h07;
        for (int i = 0; i < 3; i++) begin
            run_check(cws[i], CRC8_POLY, lat, bc);
            checks++; if (bus.syndrome !== exp_syn[i]) begin fails++; $display("FAIL vec%0d_syndrome got=%h exp=%h", i, bus.syndrome, exp_syn[i]); end
            checks++; if (bus.crc_ok !== (exp_syn[i] == '0)) begin fails++; $display("FAIL vec%0d_crc_ok got=%b exp=%b", i, bus.crc_ok, exp_syn[i] == '0); end
            $display("vector cw=%h syndrome=%h crc_ok=%b latency=%0d", cws[i], bus.syndrome, bus.crc_ok, lat);
            tick();
        end
    endtask

    // Results stay put and done stays low while no new check is started.
    task automatic test_hold();
        int done_seen = 0;
        bus.codeword = 40'h12_3456_789A;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        checks++; if (bus.syndrome !== 8'h07) begin fails++; $display("FAIL hold_syndrome got=%h exp=07", bus.syndrome); end
        checks++; if (bus.crc_ok !== 1'b0) begin fails++; $display("FAIL hold_crc_ok got=%b exp=0", bus.crc_ok); end
        checks++; if (done_seen !== 0) begin fails++; $display("FAIL hold_no_done got=%0d exp=0", done_seen); end
        $display("hold: syndrome=%h crc_ok=%b done_pulses=%0d", bus.syndrome, bus.crc_ok, done_seen);
    endtask

    // A second start mid-check, with different inputs, must be ignored.
    task automatic test_start_while_busy();
        logic [CW-1:0] cw1;
        logic [SW-1:0] exp_syn;
        logic [SW-1:0] got_syn = '0;
        int done_cnt = 0;
        cw1 = 40'h00_0000_0106;
        exp_syn = ref_rem(cw1, CRC8_POLY);
        bus.codeword = cw1;
        bus.poly     = CRC8_POLY;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < WIDTH + 10; i++) begin
            if (i == 5) begin
                bus.start    = 1'b1;
                bus.codeword = 40'hFF_FFFF_FFFF;
                bus.poly     = 9'h1D5;
            end
            if (i == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                got_syn = bus.syndrome;
            end
            tick();
        end
        checks++; if (done_cnt !== 1) begin fails++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt); end
        checks++; if (got_syn !== exp_syn) begin fails++; $display("FAIL busy_syndrome got=%h exp=%h", got_syn, exp_syn); end
        $display("start_while_busy: done_pulses=%0d syndrome=%h", done_cnt, got_syn);
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        int lat, bc;
        bus.codeword = 40'h00_0000_0000;
        bus.poly     = CRC8_POLY;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        checks++; if (bus.crc_ok !== 1'b0) begin fails++; $display("FAIL abort_crc_ok got=%b exp=0", bus.crc_ok); end
        checks++; if (bus.syndrome !== '0) begin fails++; $display("FAIL abort_syndrome got=%h exp=00", bus.syndrome); end
        for (int i = 0; i < WIDTH + 5; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        checks++; if (done_cnt !== 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        run_check(40'h00_0000_0107, CRC8_POLY, lat, bc);
        checks++; if (bus.crc_ok !== 1'b1) begin fails++; $display("FAIL abort_recheck_crc_ok got=%b exp=1", bus.crc_ok); end
        $display("reset_abort: done_after_abort=%0d recheck crc_ok=%b", done_cnt, bus.crc_ok);
        tick();
    endtask

    // Random messages with correct CRCs, some with a single flipped bit.
    task automatic test_random();
        logic [WIDTH-1:0] msg;
        logic [PW-1:0]    p;
        logic [SW-1:0]    crc, exp_syn;
        logic [CW-1:0]    cw;
        int lat, bc, flip;
        for (int i = 0; i < 24; i++) begin
            msg = $urandom;
            p   = {1'b1, 8'($urandom_range(0, 255))};
            if (i % 3 == 0) p = CRC8_POLY;
            crc = ref_rem({msg, {SW{1'b0}}}, p);
            cw  = {msg, crc};
            flip = -1;
            if ($urandom_range(0, 1) == 1) begin
                flip = $urandom_range(0, CW - 1);
                cw[flip] = ~cw[flip];
            end
            exp_syn = ref_rem(cw, p);
            run_check(cw, p, lat, bc);
            checks++; if (lat !== WIDTH + 1) begin fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, WIDTH + 1); end
            checks++; if (bus.syndrome !== exp_syn) begin fails++; $display("FAIL rand%0d_syndrome got=%h exp=%h", i, bus.syndrome, exp_syn); end
            checks++; if (bus.crc_ok !== (exp_syn == '0)) begin fails++; $display("FAIL rand%0d_crc_ok got=%b exp=%b", i, bus.crc_ok, exp_syn == '0); end
            $display("random %0d: cw=%h poly=%h flip=%0d syndrome=%h crc_ok=%b", i, cw, p, flip, bus.syndrome, bus.crc_ok);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_zero_timing();
        tick();
        test_vectors();
        test_hold();
        test_start_while_busy();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
